digit_argmax: RTL and testbench
===============================

Name: digit_argmax

Overview:
Sequential argmax unit for the digit recognizer back end. It accepts a stream of NUM_CLASSES unsigned class scores over a valid/ready handshake and produces the winning digit index and its score. It also reports a tie flag and a one-cycle done pulse. It sits between the per-class score accumulators and the result/display logic. It is the consumer of magnitude-comparison results and reduces a score vector to a single decision.

Parameters:
SCORE_W, 4, width of each unsigned class score
NUM_CLASSES, 10, number of scores per frame (legal range 2..2**IDX_W)
IDX_W, 4, width of class index and internal counter

Ports:
clk  input  1  system clock, rising edge
n_rst  input  1  synchronous active-low reset
start  input  1  begin new frame; honoured only in IDLE
score_in  input  SCORE_W  unsigned class score, presented in class order 0..NUM_CLASSES-1
score_valid  input  1  score_in valid this cycle
score_ready  output  1  block accepts score this cycle
busy  output  1  high in ACCUM
best_idx  output  IDX_W  index of winning class
best_score  output  SCORE_W  score of winning class
tie  output  1  another class equalled best_score
done  output  1  one-cycle pulse: result valid

Behaviour:
- Reset: one clock; reset is synchronous and active-low (clk, n_rst). When n_rst is low at a rising edge, the FSM goes to IDLE and the outputs reset as follows:
  - best_idx=0, best_score=0, tie=0, done=0
  - busy=0, score_ready=0, counter=0
- Reset mid-frame discards the partial frame.
- FSM: IDLE -> ACCUM on start. ACCUM -> DONE on the accepted score with counter==NUM_CLASSES-1. DONE -> IDLE unconditionally after one cycle.
- IDLE: score_ready=0 and busy=0. On start: counter<=0, tie<=0. best_idx and best_score hold their previous values until the first score is accepted.
- ACCUM: score_ready=1 and busy=1.
  - A score is accepted only when score_valid && score_ready. Cycles with score_valid low do not advance the counter.
  - start is ignored while in ACCUM.
- Compare rule on each accepted score s with index counter:
  - counter==0: best_score<=s, best_idx<=0, tie<=0.
  - s>best_score: load s and counter, tie<=0.
  - s==best_score: keep the earlier index (lowest index wins), tie<=1.
  - s<best_score: no change.
- Comparison is unsigned and full-width. There is no saturation or wrap; the counter never exceeds NUM_CLASSES-1.
- DONE: done=1 for exactly one cycle, beginning the cycle after the last score is accepted (latency 1). score_ready=0 and busy=0. start is ignored in DONE.
- best_idx, best_score and tie hold stable from DONE until the first score of the next frame is accepted.
- All outputs are registered.

Optional Feature:
Macro ARGMAX_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort high in ACCUM forces IDLE next cycle. No done pulse.
  - best_idx, best_score and tie hold their pre-abort register contents, which may be partial; consumers rely only on done.
  - abort has priority over a simultaneously accepted score; that score is discarded.
  - abort is ignored in IDLE and DONE.
- Undefined: the port is absent. A frame ends only by completion or n_rst.

Decomposition:
- Shared package digit_pkg holds:
  - the SCORE_W, NUM_CLASSES and IDX_W defaults
  - an enum typedef for states IDLE/ACCUM/DONE
  - typedefs score_t and idx_t
- One sub-module is natural: score_cmp, a combinational unsigned SCORE_W magnitude comparator with outputs gt/lt/eq, instantiated once. All registers and the FSM stay in digit_argmax.

Test Plan:
- Scores 3,7,2,9,1,0,9,4,5,8 back-to-back -> best_idx=3, best_score=9, tie=1; done high exactly the cycle after the 10th accept.
- Ten zeros -> best_idx=0, best_score=0, tie=1.
- Scores 6..15 ascending -> best_idx=9, best_score=15, tie=0. The 9s vector 9,9,0,... followed by a 12 at idx 5 -> idx=5, tie=0 (tie cleared).
- Same vector as the first case with score_valid deasserted on random cycles, plus start pulses during ACCUM -> identical result; done timing tracks the 10th accept.
- n_rst low for one cycle after 4 accepts -> all outputs zero, IDLE. A following start and the full second-scenario vector -> correct result, no stale tie.
- With ARGMAX_ABORT_EN: abort after 5 accepts -> no done, back to IDLE. A fresh frame from the first scenario -> idx=3, score=9, tie=1.

Source files
------------

// File: rtl/digit_pkg.sv
// Shared definitions for the digit recognizer argmax back end.
// Holds the default widths/count, the FSM state enum and the score/index types.
package digit_pkg;

   localparam int unsigned SCORE_W_DEF     = 4;
   localparam int unsigned NUM_CLASSES_DEF = 10;
   localparam int unsigned IDX_W_DEF       = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      DONE  = 2'd2
   } state_e;

   typedef logic [SCORE_W_DEF-1:0] score_t;
   typedef logic [IDX_W_DEF-1:0]   idx_t;

endpackage

// File: rtl/score_cmp.sv
// Combinational unsigned magnitude comparator for class scores.
// Ports:
//   a, b       : unsigned operands (W bits)
//   gt, lt, eq : a>b, a<b, a==b (exactly one is high)
module score_cmp #(
   parameter int unsigned W = 4
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         gt,
   output logic         lt,
   output logic         eq
);

   assign gt = (a > b);
   assign lt = (a < b);
   assign eq = (a == b);

endmodule

// File: rtl/digit_argmax.sv
// Sequential argmax over a frame of NUM_CLASSES unsigned scores.
// Scores arrive in class order over a valid/ready handshake; the lowest
// index among equal maxima wins and tie reports that an equal score was seen.
// Optional macro ARGMAX_ABORT_EN adds an abort input that drops the frame.
// Ports:
//   clk, n_rst   : clock, synchronous active-low reset
//   start        : begin a frame (IDLE only)
//   score_in     : class score, score_valid qualifies it
//   score_ready  : score accepted this cycle when valid (ACCUM)
//   busy         : frame in progress
//   best_idx     : winning class index
//   best_score   : winning class score
//   tie          : another class equalled best_score
//   done         : one-cycle result-valid pulse
//   abort        : (ARGMAX_ABORT_EN only) abandon current frame
module digit_argmax
   import digit_pkg::*;
#(
   parameter int unsigned SCORE_W     = SCORE_W_DEF,
   parameter int unsigned NUM_CLASSES = NUM_CLASSES_DEF,
   parameter int unsigned IDX_W       = IDX_W_DEF
) (
   input  logic               clk,
   input  logic               n_rst,
   input  logic               start,
   input  logic [SCORE_W-1:0] score_in,
   input  logic               score_valid,
`ifdef ARGMAX_ABORT_EN
   input  logic               abort,
`endif
   output logic               score_ready,
   output logic               busy,
   output logic [IDX_W-1:0]   best_idx,
   output logic [SCORE_W-1:0] best_score,
   output logic               tie,
   output logic               done
);

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLASSES - 1);

   state_e             state_q, state_d;
   logic [IDX_W-1:0]   cnt_q, cnt_d;
   logic [IDX_W-1:0]   best_idx_q, best_idx_d;
   logic [SCORE_W-1:0] best_score_q, best_score_d;
   logic               tie_q, tie_d;
   logic               ready_q, ready_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic accept_c;
   logic abort_c;
   logic last_c;
   logic gt_c, lt_c, eq_c;

   // Incoming score against the running best
   score_cmp #(
      .W (SCORE_W)
   ) u_cmp (
      .a  (score_in),
      .b  (best_score_q),
      .gt (gt_c),
      .lt (lt_c),
      .eq (eq_c)
   );

   // ready_q is only high in ACCUM, so it doubles as the state qualifier
   assign accept_c = score_valid && ready_q;
   assign last_c   = (cnt_q == LAST_IDX);

`ifdef ARGMAX_ABORT_EN
   assign abort_c = abort && (state_q == ACCUM);
`else
   assign abort_c = 1'b0;
`endif

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = ACCUM;
            end
         end
         ACCUM: begin
            // abort wins over a score accepted in the same cycle
            if (abort_c) begin
               state_d = IDLE;
            end else if (accept_c && last_c) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // Datapath next values and registered status outputs
   always_comb begin
      cnt_d        = cnt_q;
      best_idx_d   = best_idx_q;
      best_score_d = best_score_q;
      tie_d        = tie_q;

      if ((state_q == IDLE) && start) begin
         cnt_d = '0;
         tie_d = 1'b0;
      end else if (accept_c && !abort_c) begin
         if (cnt_q == '0) begin
            best_score_d = score_in;
            best_idx_d   = '0;
            tie_d        = 1'b0;
         end else begin
            case ({gt_c, eq_c, lt_c})
               3'b100: begin
                  best_score_d = score_in;
                  best_idx_d   = cnt_q;
                  tie_d        = 1'b0;
               end
               // equal score: earlier index is kept
               3'b010:  tie_d = 1'b1;
               3'b001:  tie_d = tie_q;
               default: tie_d = tie_q;
            endcase
         end
         // counter parks on the last index; next start clears it
         if (!last_c) begin
            cnt_d = cnt_q + IDX_W'(1);
         end
      end

      ready_d = (state_d == ACCUM);
      busy_d  = (state_d == ACCUM);
      done_d  = (state_d == DONE);
   end

   // State and datapath registers
   always_ff @(posedge clk) begin
      if (!n_rst) begin
         state_q      <= IDLE;
         cnt_q        <= '0;
         best_idx_q   <= '0;
         best_score_q <= '0;
         tie_q        <= 1'b0;
         ready_q      <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         best_idx_q   <= best_idx_d;
         best_score_q <= best_score_d;
         tie_q        <= tie_d;
         ready_q      <= ready_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
      end
   end

   assign score_ready = ready_q;
   assign busy        = busy_q;
   assign best_idx    = best_idx_q;
   assign best_score  = best_score_q;
   assign tie         = tie_q;
   assign done        = done_q;

endmodule

// File: tb/tb_digit_argmax.sv
// Self-checking bench for digit_argmax: directed vector table, reset and
// (when ARGMAX_ABORT_EN is defined) abort sequences, and random frames
// checked against a max/first-index/count reference model.
module tb_digit_argmax;
   import digit_pkg::*;

   localparam int NC = 10;

   typedef logic [3:0] vec_t [NC];
   typedef struct {
      vec_t s;
      int   e_idx;
      int   e_score;
      bit   e_tie;
   } rec_t;

   logic       clk = 1'b0;
   logic       n_rst, start, score_valid;
   logic [3:0] score_in;
   logic       score_ready, busy, tie, done;
   logic [3:0] best_idx, best_score;
`ifdef ARGMAX_ABORT_EN
   logic       abort;
`endif

   int checks = 0;
   int errors = 0;
   int prev_idx = 0, prev_score = 0;
   bit prev_tie = 0;

   digit_argmax dut (
      .clk         (clk),
      .n_rst       (n_rst),
      .start       (start),
      .score_in    (score_in),
      .score_valid (score_valid),
`ifdef ARGMAX_ABORT_EN
      .abort       (abort),
`endif
      .score_ready (score_ready),
      .busy        (busy),
      .best_idx    (best_idx),
      .best_score  (best_score),
      .tie         (tie),
      .done        (done)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: maximum, first index holding it, tie if it occurs more than once
   function automatic void ref_model(input vec_t s, output int bi, output int bs, output bit t);
      int n;
      bs = 0;
      for (int i = 0; i < NC; i++) if (int'(s[i]) > bs) bs = int'(s[i]);
      bi = -1;
      n  = 0;
      for (int i = 0; i < NC; i++) begin
         if (int'(s[i]) == bs) begin
            if (bi < 0) bi = i;
            n++;
         end
      end
      t = (n > 1);
   endfunction

   // One full frame; gaps inserts idle cycles and stray start pulses
   task automatic run_frame(input vec_t s, input bit gaps, input int e_idx,
                            input int e_score, input bit e_tie, input string tag);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk({tag, " busy"}, busy, 1);
      chk({tag, " hold_idx"}, best_idx, prev_idx);
      chk({tag, " hold_score"}, best_score, prev_score);
      chk({tag, " start_tie"}, tie, 0);
      for (int i = 0; i < NC; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
               score_valid = 1'b0;
               start       = 1'($urandom_range(0, 1));
               score_in    = 4'($urandom);
               @(negedge clk);
               chk({tag, " gap_done"}, done, 0);
            end
         end
         start       = gaps ? 1'($urandom_range(0, 1)) : 1'b0;
         score_valid = 1'b1;
         score_in    = s[i];
         chk({tag, " ready"}, score_ready, 1);
         chk({tag, " early_done"}, done, 0);
         @(negedge clk);
      end
      score_valid = 1'b0;
      start       = 1'b0;
      chk({tag, " done"}, done, 1);
      chk({tag, " done_busy"}, busy, 0);
      chk({tag, " done_ready"}, score_ready, 0);
      chk({tag, " idx"}, best_idx, e_idx);
      chk({tag, " score"}, best_score, e_score);
      chk({tag, " tie"}, tie, e_tie);
      @(negedge clk);
      chk({tag, " done_pulse"}, done, 0);
      chk({tag, " idx_stable"}, best_idx, e_idx);
      chk({tag, " tie_stable"}, tie, e_tie);
      prev_idx   = e_idx;
      prev_score = e_score;
      prev_tie   = e_tie;
   endtask

   task automatic partial_frame(input int n);
      @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < n; i++) begin
         score_valid = 1'b1;
         score_in    = 4'(i + 5);
         @(negedge clk);
      end
   endtask

   rec_t tbl[5];
   vec_t rv;
   int   ri, rs;
   bit   rt;

   initial begin
      tbl[0].s = '{4'd3, 4'd7, 4'd2, 4'd9, 4'd1, 4'd0, 4'd9, 4'd4, 4'd5, 4'd8};
      tbl[0].e_idx = 3; tbl[0].e_score = 9;  tbl[0].e_tie = 1;
      tbl[1].s = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
      tbl[1].e_idx = 0; tbl[1].e_score = 0;  tbl[1].e_tie = 1;
      tbl[2].s = '{4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15};
      tbl[2].e_idx = 9; tbl[2].e_score = 15; tbl[2].e_tie = 0;
      tbl[3].s = '{4'd9, 4'd9, 4'd0, 4'd0, 4'd0, 4'd12, 4'd0, 4'd0, 4'd0, 4'd0};
      tbl[3].e_idx = 5; tbl[3].e_score = 12; tbl[3].e_tie = 0;
      tbl[4].s = '{4'd2, 4'd1, 4'd0, 4'd1, 4'd2, 4'd0, 4'd1, 4'd2, 4'd0, 4'd15};
      tbl[4].e_idx = 9; tbl[4].e_score = 15; tbl[4].e_tie = 0;

      n_rst       = 1'b0;
      start       = 1'b0;
      score_valid = 1'b0;
      score_in    = '0;
`ifdef ARGMAX_ABORT_EN
      abort       = 1'b0;
`endif
      repeat (3) @(negedge clk);
      chk("rst idx", best_idx, 0);
      chk("rst score", best_score, 0);
      chk("rst tie", tie, 0);
      chk("rst done", done, 0);
      chk("rst busy", busy, 0);
      chk("rst ready", score_ready, 0);
      n_rst = 1'b1;
      @(negedge clk);
      chk("idle ready", score_ready, 0);

      for (int k = 0; k < 5; k++)
         run_frame(tbl[k].s, 1'b0, tbl[k].e_idx, tbl[k].e_score, tbl[k].e_tie,
                   $sformatf("tbl%0d", k));

      // first vector again with bubbles and ignored start pulses
      run_frame(tbl[0].s, 1'b1, 3, 9, 1'b1, "gaps");

      // reset mid-frame
      partial_frame(4);
      score_valid = 1'b0;
      n_rst       = 1'b0;
      @(negedge clk);
      chk("midrst idx", best_idx, 0);
      chk("midrst score", best_score, 0);
      chk("midrst tie", tie, 0);
      chk("midrst busy", busy, 0);
      chk("midrst ready", score_ready, 0);
      chk("midrst done", done, 0);
      n_rst      = 1'b1;
      prev_idx   = 0;
      prev_score = 0;
      run_frame(tbl[1].s, 1'b0, 0, 0, 1'b1, "postrst");
      run_frame(tbl[2].s, 1'b0, 9, 15, 1'b0, "postrst2");

`ifdef ARGMAX_ABORT_EN
      partial_frame(5);
      score_valid = 1'b1;
      score_in    = 4'd15;
      abort       = 1'b1;
      @(negedge clk);
      abort       = 1'b0;
      score_valid = 1'b0;
      chk("abort busy", busy, 0);
      chk("abort ready", score_ready, 0);
      chk("abort done", done, 0);
      chk("abort score", best_score, 9);
      @(negedge clk);
      chk("abort done2", done, 0);
      prev_idx   = int'(best_idx);
      prev_score = int'(best_score);
      run_frame(tbl[0].s, 1'b0, 3, 9, 1'b1, "postabort");
      // abort outside ACCUM has no effect
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      run_frame(tbl[3].s, 1'b0, 5, 12, 1'b0, "idleabort");
`endif

      for (int k = 0; k < 20; k++) begin
         for (int i = 0; i < NC; i++)
            rv[i] = (k % 2 == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 3));
         ref_model(rv, ri, rs, rt);
         run_frame(rv, 1'((k % 3) == 0), ri, rs, rt, $sformatf("rand%0d", k));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
